// File: rtl/cmp_result_filter_if.sv
// Bundles the comparator-result filter's sample inputs and debounced outputs.
//   enable, eq, gt, lt, clr : sample qualifier, comparator flags, counter/err clear
//   stable_eq/gt/lt, change : debounced relation and its one-cycle update pulse
//   eq_cnt, gt_cnt, lt_cnt  : saturating per-relation sample counters
//   err                     : sticky illegal-sample flag
//   dbg_state               : current FSM state encoding, for observation only
// Handshake: there is no backpressure. Each rising clock edge with enable=1 is
// one sample; every output is valid on every cycle and is updated only on
// clock edges (or cleared by the asynchronous reset).
interface cmp_result_filter_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             clr;
    logic             stable_eq;
    logic             stable_gt;
    logic             stable_lt;
    logic             change;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic             err;
    logic [1:0]       dbg_state;

    modport master (
        output enable, eq, gt, lt, clr,
        input  stable_eq, stable_gt, stable_lt, change,
        input  eq_cnt, gt_cnt, lt_cnt, err, dbg_state
    );

    modport slave (
        input  enable, eq, gt, lt, clr,
        output stable_eq, stable_gt, stable_lt, change,
        output eq_cnt, gt_cnt, lt_cnt, err, dbg_state
    );
endinterface

// File: rtl/cmp_result_filter.sv
// Debounces the eq/gt/lt outputs of a magnitude comparator into a stable
// registered relation, counts accepted samples per relation (saturating) and
// flags non-one-hot samples.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cmp_result_filter_if slave (sample inputs, debounced outputs)
module cmp_result_filter #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cmp_result_filter_if.slave    bus
);
    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_EQ   = 2'd1,
        S_GT   = 2'd2,
        S_LT   = 2'd3
    } state_t;

    // Candidate relation uses the same encoding as the state so a finished run
    // maps directly onto its target state.
    localparam logic [3:0] RUN_MAX = 4'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    state_t           cand, cand_nxt;
    state_t           samp;
    logic [3:0]       run, run_nxt;
    logic             change_nxt;
    logic             valid, illegal;
    logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt;
    logic             err;

    assign valid   = bus.enable & $onehot({bus.eq, bus.gt, bus.lt});
    assign illegal = bus.enable & ~$onehot({bus.eq, bus.gt, bus.lt});

    always_comb begin
        samp = S_LT;
        if (bus.eq)      samp = S_EQ;
        else if (bus.gt) samp = S_GT;
    end

    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        run_nxt    = run;
        change_nxt = 1'b0;
        if (illegal) begin
            // A glitchy sample breaks the current run but leaves the stable relation alone.
            cand_nxt = S_NONE;
            run_nxt  = 4'd0;
        end else if (valid) begin
            if (samp == cand) begin
                run_nxt = (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
            end else begin
                cand_nxt = samp;
                run_nxt  = 4'd1;
            end
            if (run_nxt == RUN_MAX && state != samp) begin
                state_nxt  = samp;
                change_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_NONE;
            cand       <= S_NONE;
            run        <= 4'd0;
            bus.change <= 1'b0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            run        <= run_nxt;
            bus.change <= change_nxt;
        end
    end

    // clr has priority over a same-edge increment or error set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_cnt <= '0;
            gt_cnt <= '0;
            lt_cnt <= '0;
            err    <= 1'b0;
        end else if (bus.clr) begin
            eq_cnt <= '0;
            gt_cnt <= '0;
            lt_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (illegal) err <= 1'b1;
            if (valid) begin
                case (samp)
                    S_EQ:    if (eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
                    S_GT:    if (gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
                    default: if (lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
                endcase
            end
        end
    end

    assign bus.stable_eq = (state == S_EQ);
    assign bus.stable_gt = (state == S_GT);
    assign bus.stable_lt = (state == S_LT);
    assign bus.eq_cnt    = eq_cnt;
    assign bus.gt_cnt    = gt_cnt;
    assign bus.lt_cnt    = lt_cnt;
    assign bus.err       = err;
    assign bus.dbg_state = state;
endmodule
